// File: rtl/reg_dump.sv
// reg_dump: walks a register-file read port from FIRST_REG up to LAST_REG and
// streams every value out over a valid/ready handshake, one FETCH/PRESENT pair
// per word, closing each pass with a one-cycle DONE pulse.
// Optional feature macro: REG_DUMP_CSUM_EN appends an XOR checksum word (CSUM
// state) after the last register. Without it the pass is purely the registers.
module reg_dump #(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [4:0]  ra,
   input  logic [31:0] busA,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_idx,
   output logic        out_last,
   output logic        busy,
   output logic        done
);

   localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
   localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_PRESENT = 3'd2,
      S_DONE    = 3'd3
`ifdef REG_DUMP_CSUM_EN
      ,
      S_CSUM    = 3'd4
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  ra_q, ra_d;
   logic [31:0] out_data_q, out_data_d;
   logic [4:0]  out_idx_q, out_idx_d;
   logic        out_last_q, out_last_d;
   logic        out_valid_q, out_valid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        xfer_s;
   logic        at_last_s;

`ifdef REG_DUMP_CSUM_EN
   logic [31:0] acc_q, acc_d;

   // Running checksum: XOR of every register word accepted so far.
   function automatic logic [31:0] csum_fold(input logic [31:0] acc, input logic [31:0] word);
      return acc ^ word;
   endfunction
`endif

   // A word moves only while it is presented and the consumer accepts it;
   // out_valid is low outside PRESENT/CSUM, so out_ready is ignored there.
   assign xfer_s    = out_valid_q & out_ready;
   assign at_last_s = (ra_q == LAST_IDX);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (xfer_s) begin
               if (at_last_s) begin
`ifdef REG_DUMP_CSUM_EN
                  state_d = S_CSUM;
`else
                  state_d = S_DONE;
`endif
               end else begin
                  state_d = S_FETCH;
               end
            end else begin
               state_d = S_PRESENT;
            end
         end
`ifdef REG_DUMP_CSUM_EN
         S_CSUM: begin
            if (xfer_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_CSUM;
            end
         end
`endif
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Datapath next values: read address walk, captured word and checksum.
   always_comb begin
      ra_d       = ra_q;
      out_data_d = out_data_q;
      out_idx_d  = out_idx_q;
      out_last_d = out_last_q;
`ifdef REG_DUMP_CSUM_EN
      acc_d      = acc_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               ra_d = FIRST_IDX;
`ifdef REG_DUMP_CSUM_EN
               acc_d = 32'd0;
`endif
            end else begin
               ra_d = ra_q;
            end
         end
         S_FETCH: begin
            // ra has been stable for the whole cycle, so busA has settled.
            out_data_d = busA;
            out_idx_d  = ra_q;
`ifdef REG_DUMP_CSUM_EN
            out_last_d = 1'b0;
`else
            out_last_d = at_last_s;
`endif
         end
         S_PRESENT: begin
            if (xfer_s) begin
`ifdef REG_DUMP_CSUM_EN
               acc_d = csum_fold(acc_q, out_data_q);
`endif
               if (at_last_s) begin
                  // ra stays on LAST_REG; it never wraps past the end.
                  ra_d = ra_q;
`ifdef REG_DUMP_CSUM_EN
                  out_data_d = csum_fold(acc_q, out_data_q);
                  out_idx_d  = 5'd0;
                  out_last_d = 1'b1;
`endif
               end else begin
                  ra_d = ra_q + 5'd1;
               end
            end else begin
               ra_d = ra_q;
            end
         end
         default: begin
            ra_d = ra_q;
         end
      endcase
   end

   // Output flag next values, decoded from the next state so they register in step.
   always_comb begin
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      case (state_d)
         S_IDLE: begin
            out_valid_d = 1'b0;
         end
         S_FETCH: begin
            busy_d = 1'b1;
         end
         S_PRESENT: begin
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
         end
`ifdef REG_DUMP_CSUM_EN
         S_CSUM: begin
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
         end
`endif
         S_DONE: begin
            busy_d = 1'b1;
            done_d = 1'b1;
         end
         default: begin
            out_valid_d = 1'b0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra_q       <= 5'd0;
         out_data_q <= 32'd0;
         out_idx_q  <= 5'd0;
         out_last_q <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
         acc_q      <= 32'd0;
`endif
      end else begin
         ra_q       <= ra_d;
         out_data_q <= out_data_d;
         out_idx_q  <= out_idx_d;
         out_last_q <= out_last_d;
`ifdef REG_DUMP_CSUM_EN
         acc_q      <= acc_d;
`endif
      end
   end

   // Output flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign ra        = ra_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: a default-parameter instance and a FIRST_REG=LAST_REG=5
// instance share clock, reset and a register-file model. Expected words come
// from a queue built straight from the register contents for each pass.
`timescale 1ns/1ps
module tb_reg_dump;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  i;
      logic        l;
   } word_t;

`ifdef REG_DUMP_CSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] regs [32];

   logic        start0, ready0, valid0, last0, busy0, done0;
   logic [4:0]  ra0, idx0;
   logic [31:0] busa0, data0;
   logic        start5, ready5, valid5, last5, busy5, done5;
   logic [4:0]  ra5, idx5;
   logic [31:0] busa5, data5;

   logic        sel5;
   logic        start_s;
   logic        ready_s;
   logic        obs_valid, obs_last, obs_busy, obs_done;
   logic [4:0]  obs_ra, obs_idx;
   logic [31:0] obs_data;

   int          errors;
   int          checks;
   word_t       exp_q [$];

   assign busa0 = regs[ra0];
   assign busa5 = regs[ra5];

   assign start0 = start_s & ~sel5;
   assign ready0 = ready_s & ~sel5;
   assign start5 = start_s & sel5;
   assign ready5 = ready_s & sel5;

   assign obs_valid = sel5 ? valid5 : valid0;
   assign obs_last  = sel5 ? last5  : last0;
   assign obs_busy  = sel5 ? busy5  : busy0;
   assign obs_done  = sel5 ? done5  : done0;
   assign obs_ra    = sel5 ? ra5    : ra0;
   assign obs_idx   = sel5 ? idx5   : idx0;
   assign obs_data  = sel5 ? data5  : data0;

   reg_dump dut (
      .clk(clk), .rst_n(rst_n), .start(start0), .ra(ra0), .busA(busa0),
      .out_valid(valid0), .out_ready(ready0), .out_data(data0), .out_idx(idx0),
      .out_last(last0), .busy(busy0), .done(done0)
   );

   reg_dump #(.FIRST_REG(5), .LAST_REG(5)) dut5 (
      .clk(clk), .rst_n(rst_n), .start(start5), .ra(ra5), .busA(busa5),
      .out_valid(valid5), .out_ready(ready5), .out_data(data5), .out_idx(idx5),
      .out_last(last5), .busy(busy5), .done(done5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Expected stream: every register in range in order, last flag on the final
   // register unless a checksum word (XOR of all of them) closes the pass.
   function automatic void build_model(input int first, input int last);
      logic [31:0] acc;
      word_t w;
      acc = 32'd0;
      exp_q.delete();
      for (int k = first; k <= last; k++) begin
         w.d = regs[k];
         w.i = 5'(k);
         w.l = (k == last) && !CSUM;
         acc = acc ^ regs[k];
         exp_q.push_back(w);
      end
      if (CSUM) begin
         w.d = acc;
         w.i = 5'd0;
         w.l = 1'b1;
         exp_q.push_back(w);
      end
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ra"},    32'(ra0),    32'd0);
      check({tag, "_valid"}, 32'(valid0), 32'd0);
      check({tag, "_data"},  data0,       32'd0);
      check({tag, "_idx"},   32'(idx0),   32'd0);
      check({tag, "_last"},  32'(last0),  32'd0);
      check({tag, "_busy"},  32'(busy0),  32'd0);
      check({tag, "_done"},  32'(done0),  32'd0);
   endtask

   task automatic idle_quiet(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check({tag, "_busy"}, 32'(obs_busy), 32'd0);
         check({tag, "_done"}, 32'(obs_done), 32'd0);
      end
   endtask

   // One dump pass on the selected instance. Inputs change at negedge; the
   // word on the bus at a negedge transfers at the following posedge if ready.
   task automatic run_pass(input bit use5, input bit rand_ready, input int stall_idx,
                           input int stall_len, input bit mid_start, input int abort_idx,
                           input bit hold_start);
      int          first, last, nregs, present_cyc, busy_cyc, stall_left, c;
      bit          finished, held;
      logic [31:0] h_data;
      logic [4:0]  h_idx;
      first       = use5 ? 5 : 0;
      last        = use5 ? 5 : 31;
      nregs       = last - first + 1;
      present_cyc = 0;
      busy_cyc    = 0;
      stall_left  = stall_len;
      finished    = 1'b0;
      held        = 1'b0;
      h_data      = 32'd0;
      h_idx       = 5'd0;
      build_model(first, last);
      sel5    = use5;
      ready_s = 1'b1;
      @(negedge clk);
      start_s = 1'b1;
      @(negedge clk);
      if (!hold_start) start_s = 1'b0;
      check("busy_after_start", 32'(obs_busy), 32'd1);
      check("first_ra", 32'(obs_ra), 32'(first));
      for (c = 0; c < 3000 && !finished; c++) begin
         if (obs_busy) busy_cyc++;
         if (obs_done) begin
            finished = 1'b1;
         end else begin
            ready_s = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (obs_valid && stall_left > 0 && int'(obs_idx) == stall_idx) begin
               if (held) begin
                  check("stall_data", obs_data, h_data);
                  check("stall_idx", 32'(obs_idx), 32'(h_idx));
                  check("stall_valid", 32'(obs_valid), 32'd1);
                  check("stall_ra", 32'(obs_ra), 32'(stall_idx));
               end
               held       = 1'b1;
               h_data     = obs_data;
               h_idx      = obs_idx;
               ready_s    = 1'b0;
               stall_left = stall_left - 1;
            end
            if (obs_valid) begin
               present_cyc++;
               if (abort_idx >= 0 && int'(obs_idx) == abort_idx) begin
                  rst_n = 1'b0;
                  #1;
                  check_reset_outputs("abort");
                  @(negedge clk);
                  rst_n   = 1'b1;
                  ready_s = 1'b0;
                  idle_quiet("after_abort", 6);
                  return;
               end
               if (exp_q.size() == 0) begin
                  check("extra_word", 32'd1, 32'd0);
               end else begin
                  check("word_data", obs_data, exp_q[0].d);
                  check("word_idx", 32'(obs_idx), 32'(exp_q[0].i));
                  check("word_last", 32'(obs_last), 32'(exp_q[0].l));
                  if (ready_s) void'(exp_q.pop_front());
               end
            end
            if (mid_start) start_s = (c == 6 || c == 7 || c == 30);
            @(negedge clk);
         end
      end
      if (!hold_start) start_s = 1'b0;
      check("pass_completed", 32'(finished), 32'd1);
      check("words_left", 32'(exp_q.size()), 32'd0);
      check("busy_in_done", 32'(obs_busy), 32'd1);
      check("valid_in_done", 32'(obs_valid), 32'd0);
      if (!rand_ready && stall_len == 0) begin
         // Full speed: FETCH+PRESENT per register, a CSUM cycle if present, DONE.
         check("busy_cycles_full", 32'(busy_cyc), 32'(2 * nregs + 1 + (CSUM ? 1 : 0)));
      end else begin
         check("busy_cycles", 32'(busy_cyc), 32'(nregs + present_cyc + 1));
      end
      @(negedge clk);
      check("done_one_cycle", 32'(obs_done), 32'd0);
      check("idle_after_done", 32'(obs_busy), 32'd0);
      if (hold_start) begin
         @(negedge clk);
         check("restart_on_held_start", 32'(obs_busy), 32'd1);
         start_s  = 1'b0;
         finished = 1'b0;
         for (c = 0; c < 200 && !finished; c++) begin
            @(negedge clk);
            if (obs_done) finished = 1'b1;
         end
         check("second_pass_done", 32'(finished), 32'd1);
         @(negedge clk);
         check("idle_after_second", 32'(obs_busy), 32'd0);
      end else begin
         idle_quiet("stays_idle", 3);
      end
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      sel5    = 1'b0;
      start_s = 1'b0;
      ready_s = 1'b0;
      for (int k = 0; k < 32; k++) regs[k] = 32'(k) * 32'h11;
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset");
      check("reset5_busy", 32'(busy5), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle_quiet("no_start", 4);

      // Preloaded pattern, consumer always ready.
      run_pass(1'b0, 1'b0, -1, 0, 1'b0, -1, 1'b0);

      // Backpressure for five cycles on register 3.
      run_pass(1'b0, 1'b0, 3, 5, 1'b0, -1, 1'b0);

      // Random contents, random ready, stray start pulses mid-pass.
      for (int k = 0; k < 32; k++) regs[k] = $urandom;
      run_pass(1'b0, 1'b1, -1, 0, 1'b1, -1, 1'b0);

      // Single-register instance, start held high across the pass.
      run_pass(1'b1, 1'b1, -1, 0, 1'b0, -1, 1'b1);

      // Reset while presenting register 10, then a fresh pass from 0.
      run_pass(1'b0, 1'b0, -1, 0, 1'b0, 10, 1'b0);
      for (int k = 0; k < 32; k++) regs[k] = $urandom;
      run_pass(1'b0, 1'b0, -1, 0, 1'b0, -1, 1'b0);

`ifdef REG_DUMP_CSUM_EN
      regs[0] = 32'd0;
      for (int k = 1; k < 32; k++) regs[k] = 32'hFFFF_FFFF;
      build_model(0, 31);
      check("csum_word_value", exp_q[32].d, 32'hFFFF_FFFF);
      run_pass(1'b0, 1'b0, -1, 0, 1'b0, -1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
